// File: rtl/rvv_backend_uq_credit_ctrl.sv
// rtl/rvv_backend_uq_credit_ctrl.sv - credit-based push scheduler between decode and the Uop Queue
//
// Purpose: tracks free Uop Queue slots as credits. Each cycle it grants up to
// NUM_PUSH pushes from the contiguous low run of decode requests. Popped
// entries return their credits. A trap flush refills the pool and blocks
// grants for FLUSH_HOLD cycles.
//
// Optional build macro: RVV_UQ_CREDIT_BYPASS_EN lets credits freed by a
// same-cycle pop be granted in that cycle.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   push_req[NUM_PUSH]      decode push requests, bit i = uop i
//   push_grant[NUM_PUSH]    combinational grants, low n_grant bits set
//   pop_uq[NUM_POP]         Uop Queue entries released this cycle
//   trap_flush_rvv          flush; the Uop Queue empties this cycle
//   credit_cnt              registered free-slot count
//   fifo_full_uq2de         registered, credit_cnt == 0
//   fifo_almost_full_uq2de  registered, bit i = (credit_cnt <= i)
//   credit_err              sticky, credit return beyond UQ_DEPTH
module rvv_backend_uq_credit_ctrl #(
    parameter int UQ_DEPTH   = 16,
    parameter int NUM_PUSH   = 4,
    parameter int NUM_POP    = 2,
    parameter int FLUSH_HOLD = 2,
    localparam int CW        = $clog2(UQ_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PUSH-1:0] push_req,
    output logic [NUM_PUSH-1:0] push_grant,
    input  logic [NUM_POP-1:0]  pop_uq,
    input  logic                trap_flush_rvv,
    output logic [CW-1:0]       credit_cnt,
    output logic                fifo_full_uq2de,
    output logic [NUM_PUSH-1:0] fifo_almost_full_uq2de,
    output logic                credit_err
);

    localparam int NW = CW + 1;
    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [NW-1:0] DEPTH_W   = NW'(UQ_DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(UQ_DEPTH);
    localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_HOLD - 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic                full_q, full_d;
    logic [NUM_PUSH-1:0] afull_q, afull_d;
    logic                err_q, err_d;

    logic [NW-1:0] n_req, n_pop, n_avail, n_grant, sum_next;
    logic          run_done;
    logic          grant_en;

    always_comb begin
        // Length of the run of 1s starting at bit 0; stop at the first 0.
        n_req    = '0;
        run_done = 1'b0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (!run_done && push_req[i]) begin
                n_req = n_req + NW'(1);
            end else begin
                run_done = 1'b1;
            end
        end

        n_pop = '0;
        for (int j = 0; j < NUM_POP; j++) begin
            n_pop = n_pop + NW'(pop_uq[j]);
        end

`ifdef RVV_UQ_CREDIT_BYPASS_EN
        // Same-cycle pops add credits, capped at the pool size.
        n_avail = {1'b0, credit_q} + n_pop;
        if (n_avail > DEPTH_W) begin
            n_avail = DEPTH_W;
        end
`else
        n_avail = {1'b0, credit_q};
`endif

        // Grants are also held off while rst is asserted.
        grant_en = !rst && (state_q == ST_RUN) && !trap_flush_rvv;
        n_grant  = '0;
        if (grant_en) begin
            n_grant = (n_req < n_avail) ? n_req : n_avail;
        end

        for (int i = 0; i < NUM_PUSH; i++) begin
            push_grant[i] = (NW'(i) < n_grant);
        end

        // n_grant never exceeds credit_q + n_pop, so this cannot underflow.
        sum_next = {1'b0, credit_q} - n_grant + n_pop;

        state_d  = state_q;
        hold_d   = hold_q;
        credit_d = credit_q;
        err_d    = err_q;

        if (trap_flush_rvv) begin
            // The queue is empty: drop this cycle's pops and refill the pool.
            state_d  = ST_FLUSH;
            hold_d   = HOLD_INIT;
            credit_d = DEPTH_C;
        end else if (state_q == ST_FLUSH) begin
            credit_d = DEPTH_C;
            if (hold_q == '0) begin
                state_d = ST_RUN;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end else begin
            if (sum_next > DEPTH_W) begin
                err_d    = 1'b1;
                credit_d = DEPTH_C;
            end else begin
                credit_d = sum_next[CW-1:0];
            end
        end

        // Flags track the next credit value so they line up with credit_cnt.
        full_d = (credit_d == '0);
        for (int i = 0; i < NUM_PUSH; i++) begin
            afull_d[i] = ({1'b0, credit_d} <= NW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            hold_q   <= '0;
            credit_q <= DEPTH_C;
            full_q   <= 1'b0;
            afull_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            credit_q <= credit_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            err_q    <= err_d;
        end
    end

    assign credit_cnt             = credit_q;
    assign fifo_full_uq2de        = full_q;
    assign fifo_almost_full_uq2de = afull_q;
    assign credit_err             = err_q;

endmodule

// File: tb/tb_rvv_backend_uq_credit_ctrl.sv
// tb/tb_rvv_backend_uq_credit_ctrl.sv - scoreboard bench for rvv_backend_uq_credit_ctrl
module tb_rvv_backend_uq_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] push_req = '0;
    logic [3:0] push_grant;
    logic [1:0] pop_uq = '0;
    logic       trap_flush_rvv = 1'b0;
    logic [4:0] credit_cnt;
    logic       fifo_full_uq2de;
    logic [3:0] fifo_almost_full_uq2de;
    logic       credit_err;

    rvv_backend_uq_credit_ctrl #(
        .UQ_DEPTH(16), .NUM_PUSH(4), .NUM_POP(2), .FLUSH_HOLD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_req(push_req),
        .push_grant(push_grant),
        .pop_uq(pop_uq),
        .trap_flush_rvv(trap_flush_rvv),
        .credit_cnt(credit_cnt),
        .fifo_full_uq2de(fifo_full_uq2de),
        .fifo_almost_full_uq2de(fifo_almost_full_uq2de),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [4:0] credit;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest
    // expectation at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] af;
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) af[i] = (e.credit <= 5'(i));
            chk("push_grant", e.tag, 32'(push_grant), 32'(e.grant));
            chk("credit_cnt", e.tag, 32'(credit_cnt), 32'(e.credit));
            chk("fifo_full", e.tag, 32'(fifo_full_uq2de), 32'(e.credit == 5'd0));
            chk("almost_full", e.tag, 32'(fifo_almost_full_uq2de), 32'(af));
            chk("credit_err", e.tag, 32'(credit_err), 32'(e.err));
        end
    end

    // Drive one cycle of inputs and record the outputs expected in that cycle.
    task automatic step(input string tag, input logic r, input logic [3:0] req, input logic [1:0] pop,
                        input logic fl, input logic [3:0] g, input logic [4:0] c, input logic e);
        exp_t x;
        rst = r; push_req = req; pop_uq = pop; trap_flush_rvv = fl;
        x.tag = tag; x.grant = g; x.credit = c; x.err = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        //    tag          rst req      pop    fl  grant    credit e
        step("reset",      1, 4'b1111, 2'b00, 0, 4'b0000, 5'd16, 0);
        step("fill1",      0, 4'b1111, 2'b00, 0, 4'b1111, 5'd16, 0);
        step("fill2",      0, 4'b1111, 2'b00, 0, 4'b1111, 5'd12, 0);
        step("fill3",      0, 4'b1111, 2'b00, 0, 4'b1111, 5'd8,  0);
        step("fill4",      0, 4'b1111, 2'b00, 0, 4'b1111, 5'd4,  0);
        step("full",       0, 4'b1111, 2'b00, 0, 4'b0000, 5'd0,  0);
`ifdef RVV_UQ_CREDIT_BYPASS_EN
        step("byp_pop",    0, 4'b0001, 2'b11, 0, 4'b0001, 5'd0,  0);
        step("byp_after",  0, 4'b0000, 2'b00, 0, 4'b0000, 5'd1,  0);
`else
        step("nobyp_pop",  0, 4'b0001, 2'b11, 0, 4'b0000, 5'd0,  0);
        step("nobyp_nxt",  0, 4'b0001, 2'b00, 0, 4'b0001, 5'd2,  0);
        step("nobyp_end",  0, 4'b0000, 2'b00, 0, 4'b0000, 5'd1,  0);
`endif
        step("to2",        0, 4'b0000, 2'b01, 0, 4'b0000, 5'd1,  0);
        step("part_grant", 0, 4'b1111, 2'b00, 0, 4'b0011, 5'd2,  0);
        step("af_all",     0, 4'b0000, 2'b00, 0, 4'b0000, 5'd0,  0);
        step("ret2",       0, 4'b0000, 2'b11, 0, 4'b0000, 5'd0,  0);
        step("ret4",       0, 4'b0000, 2'b11, 0, 4'b0000, 5'd2,  0);
        step("ret5",       0, 4'b0000, 2'b01, 0, 4'b0000, 5'd4,  0);
        step("flush",      0, 4'b1111, 2'b11, 1, 4'b0000, 5'd5,  0);
        step("hold1",      0, 4'b1111, 2'b00, 0, 4'b0000, 5'd16, 0);
        step("hold2_pop",  0, 4'b1111, 2'b11, 0, 4'b0000, 5'd16, 0);
        step("post_flush", 0, 4'b1111, 2'b00, 0, 4'b1111, 5'd16, 0);
        step("cnt12",      0, 4'b0000, 2'b11, 0, 4'b0000, 5'd12, 0);
        step("cnt14",      0, 4'b0000, 2'b11, 0, 4'b0000, 5'd14, 0);
        step("noncontig",  0, 4'b1101, 2'b00, 0, 4'b0001, 5'd16, 0);
        step("cnt15",      0, 4'b0000, 2'b01, 0, 4'b0000, 5'd15, 0);
        step("over_pop",   0, 4'b0000, 2'b01, 0, 4'b0000, 5'd16, 0);
        step("err_set",    0, 4'b0011, 2'b00, 0, 4'b0011, 5'd16, 1);
        step("err_sticky", 0, 4'b0000, 2'b00, 0, 4'b0000, 5'd14, 1);
        step("err_rst",    1, 4'b1111, 2'b00, 0, 4'b0000, 5'd14, 1);
        step("after_rst",  0, 4'b0000, 2'b00, 0, 4'b0000, 5'd16, 0);
        step("reflush1",   0, 4'b1111, 2'b00, 1, 4'b0000, 5'd16, 0);
        step("reflush2",   0, 4'b1111, 2'b00, 1, 4'b0000, 5'd16, 0);
        step("reload_h1",  0, 4'b1111, 2'b00, 0, 4'b0000, 5'd16, 0);
        step("reload_h2",  0, 4'b1111, 2'b00, 0, 4'b0000, 5'd16, 0);
        step("reload_run", 0, 4'b1111, 2'b00, 0, 4'b1111, 5'd16, 0);
        step("final",      0, 4'b0000, 2'b00, 0, 4'b0000, 5'd12, 0);
        push_req = '0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rvv_backend_uq_credit_ctrl.md
Name: rvv_backend_uq_credit_ctrl

Overview:
Credit-based push scheduler between the decode stage and the Uop Queue.
- Tracks free Uop Queue slots as a credit counter.
- Grants up to NUM_PUSH uop pushes per cycle from the contiguous low run of decode requests.
- Returns credits when uops are popped to dispatch.
- Recovers to a full credit pool after trap_flush_rvv.
- Produces the full and almost-full indications the decode controller consumes.

Parameters:
UQ_DEPTH, 16, Uop Queue entries; credit counter maximum.
NUM_PUSH, 4, max uops pushed per cycle (matches `NUM_DE_UOP).
NUM_POP, 2, max uops popped from the Uop Queue per cycle.
FLUSH_HOLD, 2, cycles grants stay blocked after a flush (≥1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
push_req  in  NUM_PUSH  decode wants to push uop i this cycle
push_grant  out  NUM_PUSH  uop i accepted into the Uop Queue this cycle
pop_uq  in  NUM_POP  Uop Queue released entry j this cycle
trap_flush_rvv  in  1  flush; the Uop Queue is emptied this cycle
credit_cnt  out  $clog2(UQ_DEPTH+1)  registered free-slot count
fifo_full_uq2de  out  1  registered; credit_cnt==0
fifo_almost_full_uq2de  out  NUM_PUSH  registered; bit i = (credit_cnt <= i)
credit_err  out  1  sticky; illegal credit return detected

Behaviour:
Reset (rst=1 at a clk edge):
- credit_cnt=UQ_DEPTH, fifo_full_uq2de=0, fifo_almost_full_uq2de=0, credit_err=0, state=RUN, hold counter=0.
- push_grant=0 during and after reset, until the first cycle with rst=0.

push_grant (combinational, same cycle as push_req):
- n_req = length of the run of consecutive 1s in push_req starting at bit 0. Bits above the first 0 are never granted.
- n_avail = credit_cnt.
- n_grant = min(n_req, n_avail, NUM_PUSH).
- push_grant = low n_grant bits set.
- push_grant = 0 whenever state≠RUN or trap_flush_rvv=1.

Credit update (registered):
- n_pop = popcount(pop_uq).
- next = credit_cnt − n_grant + n_pop.
- Width is $clog2(UQ_DEPTH+1)+1 internally; compare before truncation.
- If next > UQ_DEPTH: set credit_err (sticky until rst) and saturate credit_cnt to UQ_DEPTH.
- A grant and a pop in the same cycle are both applied.
- fifo_full_uq2de and fifo_almost_full_uq2de are derived from the registered next value, so they are aligned with credit_cnt.

State machine:
- RUN: normal operation. trap_flush_rvv=1 → FLUSH. In that cycle: pops ignored, no grants, credit_cnt loads UQ_DEPTH next cycle, hold counter loads FLUSH_HOLD−1.
- FLUSH: grants blocked; pops ignored (the queue is already empty); credit_cnt stays UQ_DEPTH. Hold counter decrements each cycle; at 0 → RUN.
- trap_flush_rvv=1 while in FLUSH: reloads the hold counter.
- rst overrides everything, including mid-FLUSH.

Boundary cases:
- credit_cnt=0 with push_req≠0: no grant; fifo_full_uq2de=1.
- A pop while credit_cnt=0: credits available the next cycle, not the same cycle (see the optional feature).
- Non-contiguous push_req (e.g. 4'b1101): only bit 0 granted.

Latency:
- Grant is 0 cycles from request.
- Credit return is 1 cycle from pop.

Optional Feature:
RVV_UQ_CREDIT_BYPASS_EN
- Defined: n_avail = credit_cnt + popcount(pop_uq), capped at UQ_DEPTH, so credits freed by a same-cycle pop can be granted that cycle. This adds a combinational path pop_uq→push_grant. In FLUSH, bypass is disabled.
- Undefined: n_avail = credit_cnt; credits return one cycle after the pop.

Test Plan:
1. Reset, then push_req=4'b1111 each cycle with no pops → grants 4,4,4,4. Then credit_cnt=0 and fifo_full_uq2de=1; the 5th cycle grants 0.
2. credit_cnt=2, push_req=4'b1111 → push_grant=4'b0011. Next cycle credit_cnt=0 and fifo_almost_full_uq2de=4'b1111.
3. credit_cnt=0, pop_uq=2'b11, push_req=4'b0001:
   - Bypass undefined → grant 0 that cycle, grant 1 the next cycle, credit_cnt ends at 1.
   - Bypass defined → grant 1 in the same cycle, credit_cnt ends at 1.
4. credit_cnt=5, trap_flush_rvv=1 with push_req=4'b1111 → grant 0. credit_cnt=16 next cycle; grants blocked for FLUSH_HOLD=2 cycles, then 4 granted.
5. credit_cnt=16, pop_uq=2'b01 → credit_err=1 and credit_cnt stays 16. credit_err persists until rst.
6. push_req=4'b1101 with credit_cnt=16 → push_grant=4'b0001; credit_cnt=15 next cycle.
